// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: LSU operation types and data-memory constants.
package riscv_pkg;

   localparam logic [31:0] DMEM_BASE_ADDR_DEFAULT = 32'h0001_0000;
   localparam logic [7:0]  DMEM_LFSR_SEED         = 8'hA5;

   typedef enum logic [1:0] {
      LSU_OP_NONE  = 2'd0,
      LSU_OP_LOAD  = 2'd1,
      LSU_OP_STORE = 2'd2
   } lsu_op_e;

   typedef enum logic [2:0] {
      LSU_DT_B  = 3'd0,
      LSU_DT_H  = 3'd1,
      LSU_DT_W  = 3'd2,
      LSU_DT_BU = 3'd3,
      LSU_DT_HU = 3'd4
   } lsu_dtype_e;

   typedef struct packed {
      logic valid;
      logic wr;
      logic err;
   } dmem_resp_t;

   // Fibonacci LFSR, taps 8,6,5,4 (maximal length)
   function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-organised data RAM with per-byte write enables and a registered read port.
module dmem_ram #(
   parameter int DEPTH_WORDS = 4096,
   parameter int ADDR_W      = 12
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   input  logic [3:0]        be,
   output logic [31:0]       rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int b = 0; b < 4; b++) begin
               if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: range decode, byte-masked RAM access, fixed-latency in-order responses.
// Optional random grant stalls are enabled by defining DMEM_RAND_STALL_EN.
module dmem_ctrl
   import riscv_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR_DEFAULT,
   parameter int          DEPTH_WORDS = 4096,
   parameter int          RESP_LAT    = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        data_req,
   input  logic        data_wr,
   output logic        data_gnt,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   input  logic [3:0]  data_be,
   output logic [31:0] data_rdata,
   output logic        data_valid,
   output logic        data_error
);

   localparam int          AW   = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

   logic          stall;
   logic          in_range;
   logic [31:0]   offset;
   logic [AW-1:0] word_idx;
   logic [31:0]   ram_rdata;
   logic [31:0]   rdata_tail;
   dmem_resp_t    pipe_in;
   dmem_resp_t    pipe [RESP_LAT];
   dmem_resp_t    tail;

   assign offset   = data_addr - BASE_ADDR;
   assign in_range = (data_addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
   assign word_idx = offset[AW+1:2];

`ifdef DMEM_RAND_STALL_EN
   logic [7:0] lfsr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) lfsr <= DMEM_LFSR_SEED;
      else       lfsr <= lfsr8_next(lfsr);
   end

   assign stall = lfsr[0];
`else
   assign stall = 1'b0;
`endif

   assign data_gnt = data_req & ~stall & ~reset;

   dmem_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .ADDR_W      (AW)
   ) u_ram (
      .clk   (clk),
      .en    (data_gnt),
      .we    (data_gnt & data_wr & in_range),
      .addr  (word_idx),
      .wdata (data_wdata),
      .be    (data_be),
      .rdata (ram_rdata)
   );

   assign pipe_in = '{valid: data_gnt, wr: data_wr, err: ~in_range};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < RESP_LAT; k++) pipe[k] <= '0;
      end else begin
         pipe[0] <= pipe_in;
         for (int k = 1; k < RESP_LAT; k++) pipe[k] <= pipe[k-1];
      end
   end

   // RAM output lands with stage 1; later stages only need the data delayed to match
   generate
      if (RESP_LAT > 1) begin : g_rd_dly
         logic [31:0] rd_q [RESP_LAT-1];

         always_ff @(posedge clk) begin
            rd_q[0] <= ram_rdata;
            for (int k = 1; k < RESP_LAT-1; k++) rd_q[k] <= rd_q[k-1];
         end

         assign rdata_tail = rd_q[RESP_LAT-2];
      end else begin : g_rd_direct
         assign rdata_tail = ram_rdata;
      end
   endgenerate

   assign tail       = pipe[RESP_LAT-1];
   assign data_valid = tail.valid;
   assign data_error = tail.valid & tail.err;
   assign data_rdata = (tail.valid & ~tail.wr & ~tail.err) ? rdata_tail : '0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: vector table, reset corner case and random traffic.
module tb_dmem_ctrl;

   localparam logic [31:0] BASE  = 32'h0001_0000;
   localparam int          DEPTH = 4096;
   localparam int          LAT   = 2;

   logic        clk;
   logic        reset;
   logic        data_req;
   logic        data_wr;
   logic        data_gnt;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [3:0]  data_be;
   logic [31:0] data_rdata;
   logic        data_valid;
   logic        data_error;

   dmem_ctrl #(
      .BASE_ADDR   (BASE),
      .DEPTH_WORDS (DEPTH),
      .RESP_LAT    (LAT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .data_req   (data_req),
      .data_wr    (data_wr),
      .data_gnt   (data_gnt),
      .data_addr  (data_addr),
      .data_wdata (data_wdata),
      .data_be    (data_be),
      .data_rdata (data_rdata),
      .data_valid (data_valid),
      .data_error (data_error)
   );

   typedef struct {
      bit [31:0] rdata;
      bit        err;
      int        cyc;
   } exp_t;

   typedef struct {
      bit        wr;
      bit [31:0] addr;
      bit [31:0] wdata;
      bit [3:0]  be;
      bit [31:0] exp_rdata;
      bit        exp_err;
   } vec_t;

   exp_t      sb [$];
   vec_t      tbl [$];
   bit [31:0] model [int];
   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int gnt_count = 0;
   int resp_count = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected simulation to finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit in_rng(input bit [31:0] a);
      return (a >= BASE) && (longint'(a) < longint'(BASE) + 4 * DEPTH);
   endfunction

   // Drive one request, hold it until granted, then record the expected response
   task automatic issue(input bit wr, input bit [31:0] addr, input bit [31:0] wdata,
                        input bit [3:0] be, input bit use_tbl,
                        input bit [31:0] t_rdata, input bit t_err);
      exp_t      e;
      int        wait_n;
      int        idx;
      bit [31:0] w;
      data_req   = 1'b1;
      data_wr    = wr;
      data_addr  = addr;
      data_wdata = wdata;
      data_be    = be;
      wait_n     = 0;
      @(negedge clk);
      while (data_gnt !== 1'b1 && wait_n < 50) begin
         wait_n++;
         @(negedge clk);
      end
      check("gnt", data_gnt, 1);
      if (data_gnt === 1'b1) begin
         gnt_count++;
         e.rdata = 0;
         e.err   = 1'b0;
         if (in_rng(addr)) begin
            idx = int'((addr - BASE) >> 2);
            w   = model.exists(idx) ? model[idx] : 32'h0;
            if (wr) begin
               for (int b = 0; b < 4; b++)
                  if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
               model[idx] = w;
            end else begin
               e.rdata = w;
            end
         end else begin
            e.err = 1'b1;
         end
         if (use_tbl) begin
            e.rdata = t_rdata;
            e.err   = t_err;
         end
         e.cyc = cyc;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      data_req = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Response monitor: pops the scoreboard on every data_valid
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            check("rst_gnt", data_gnt, 0);
            check("rst_valid", data_valid, 0);
            check("rst_rdata", data_rdata, 0);
            check("rst_error", data_error, 0);
            sb.delete();
         end else if (data_valid === 1'b1) begin
            resp_count++;
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_valid: got valid with no grant outstanding, expected none (cycle %0d)", cyc);
            end else begin
               e = sb.pop_front();
               check("rdata", data_rdata, e.rdata);
               check("error", data_error, e.err);
               check("latency", cyc - e.cyc, LAT);
            end
         end else begin
            check("valid_x", data_valid, 0);
            check("idle_rdata", data_rdata, 0);
            check("idle_error", data_error, 0);
         end
      end
   end

   initial begin
      int        r;
      bit [31:0] a;
      reset      = 1'b1;
      data_req   = 1'b0;
      data_wr    = 1'b0;
      data_addr  = '0;
      data_wdata = '0;
      data_be    = '0;

      tbl.push_back('{1'b1, BASE,              32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0});
      tbl.push_back('{1'b0, BASE,              32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0});
      tbl.push_back('{1'b1, BASE + 32'h10,     32'h1122_3344, 4'hF, 32'h0,         1'b0});
      tbl.push_back('{1'b1, BASE + 32'h10,     32'h0000_AB00, 4'h2, 32'h0,         1'b0});
      tbl.push_back('{1'b0, BASE + 32'h10,     32'h0,         4'h0, 32'h1122_AB44, 1'b0});
      tbl.push_back('{1'b0, BASE + 32'h4000,   32'h0,         4'h0, 32'h0,         1'b1});
      tbl.push_back('{1'b1, BASE + 32'h4000,   32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1});
      tbl.push_back('{1'b0, BASE,              32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0});
      tbl.push_back('{1'b0, BASE - 32'h4,      32'h0,         4'h0, 32'h0,         1'b1});
      tbl.push_back('{1'b1, BASE + 32'h3FFC,   32'hCAFE_F00D, 4'hF, 32'h0,         1'b0});
      tbl.push_back('{1'b0, BASE + 32'h3FFC,   32'h0,         4'h0, 32'hCAFE_F00D, 1'b0});
      tbl.push_back('{1'b1, BASE + 32'h10,     32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0});
      tbl.push_back('{1'b0, BASE + 32'h13,     32'h0,         4'h0, 32'h1122_AB44, 1'b0});
      tbl.push_back('{1'b1, BASE + 32'h20,     32'h0,         4'hF, 32'h0,         1'b0});
      tbl.push_back('{1'b1, BASE + 32'h20,     32'hA1B2_C3D4, 4'h9, 32'h0,         1'b0});
      tbl.push_back('{1'b0, BASE + 32'h20,     32'h0,         4'h0, 32'hA100_00D4, 1'b0});
      tbl.push_back('{1'b1, 32'hFFFF_FFFC,     32'h1234_5678, 4'hF, 32'h0,         1'b1});
      tbl.push_back('{1'b0, BASE + 32'h3FFC,   32'h0,         4'h0, 32'hCAFE_F00D, 1'b0});

      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      idle(1);

      // Table vectors back to back: also covers read-after-write to the same word
      foreach (tbl[i])
         issue(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be, 1'b1,
               tbl[i].exp_rdata, tbl[i].exp_err);
      idle(LAT + 3);

      // Two back-to-back reads of an unaligned word address
      issue(1'b0, BASE + 32'h1, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
      issue(1'b0, BASE + 32'h1, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
      idle(LAT + 3);

      // Reset one cycle after a grant: the in-flight response must vanish
      issue(1'b0, BASE, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
      reset    = 1'b1;
      data_req = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      data_req = 1'b0;
      reset    = 1'b0;
      idle(LAT + 4);
      check("sb_after_reset", sb.size(), 0);
      issue(1'b0, BASE,            32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
      issue(1'b0, BASE + 32'h3FFC, 32'h0, 4'h0, 1'b1, 32'hCAFE_F00D, 1'b0);
      idle(LAT + 3);

      // Random traffic over a 16-word window plus aliasing out-of-range addresses
      gnt_count  = 0;
      resp_count = 0;
      for (int i = 0; i < 16; i++)
         issue(1'b1, BASE + 32'h100 + 32'(4 * i), $urandom, 4'hF, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 1000; i++) begin
         r = $urandom_range(0, 9);
         if (r == 0) a = BASE + 32'h4100 + 32'(4 * $urandom_range(0, 15));
         else        a = BASE + 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
         issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), 1'b0, 32'h0, 1'b0);
         if ($urandom_range(0, 7) == 0) idle(1);
      end
      idle(LAT + 5);
      check("sb_drained", sb.size(), 0);
      check("resp_eq_gnt", resp_count, gnt_count);
      check("gnt_total", gnt_count, 1016);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
